// File: rtl/machine_ctrl.sv
// Instruction-cycle sequencer for the 8-bit RISC core: an 8-state fetch/execute loop
// that decodes state, latched opcode and the zero flag into datapath strobes.
module machine_ctrl #(
    parameter logic [2:0] HLT  = 3'b000,
    parameter logic [2:0] SKZ  = 3'b001,
    parameter logic [2:0] ADD  = 3'b010,
    parameter logic [2:0] ANDD = 3'b011,
    parameter logic [2:0] XORR = 3'b100,
    parameter logic [2:0] LDA  = 3'b101,
    parameter logic [2:0] STO  = 3'b110,
    parameter logic [2:0] JMP  = 3'b111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_acc,
    output logic       load_ir,
    output logic       rd,
    output logic       wr,
    output logic       datactl_ena,
    output logic       alu_ena,
    output logic       halt,
    output logic       instr_done
);

    localparam int unsigned SW = 3;

    localparam logic [SW-1:0] S0 = 3'd0;
    localparam logic [SW-1:0] S1 = 3'd1;
    localparam logic [SW-1:0] S2 = 3'd2;
    localparam logic [SW-1:0] S3 = 3'd3;
    localparam logic [SW-1:0] S4 = 3'd4;
    localparam logic [SW-1:0] S5 = 3'd5;
    localparam logic [SW-1:0] S6 = 3'd6;
    localparam logic [SW-1:0] S7 = 3'd7;

    logic [SW-1:0] state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic          halted_q, halted_d;
    logic          run_c;
    logic          alu_op_c;

    assign run_c    = ena && !halted_q;
    assign alu_op_c = (op_q == ADD) || (op_q == ANDD) || (op_q == XORR) || (op_q == LDA);

    // State, latched opcode and sticky halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S0;
            op_q     <= HLT;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            halted_q <= halted_d;
        end
    end

    // Next state: advance while running; HLT leaves S3 straight to a parked S0
    always_comb begin
        state_d  = S0;
        op_d     = op_q;
        halted_d = halted_q;
        if (run_c) begin
            state_d = SW'(state_q + 3'd1);
            if (state_q == S2) begin
                op_d = opcode;
            end
            if (state_q == S3 && op_q == HLT) begin
                state_d  = S0;
                halted_d = 1'b1;
            end
        end
    end

    // Strobe decode, forced quiet while stopped or halted
    always_comb begin
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        load_ir     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        datactl_ena = 1'b0;
        alu_ena     = 1'b0;
        instr_done  = 1'b0;
        if (run_c) begin
            case (state_q)
                S0: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                end
                S1: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end
                S3: inc_pc = 1'b1;
                S4: begin
                    if (alu_op_c) begin
                        rd      = 1'b1;
                        alu_ena = 1'b1;
                    end else if (op_q == JMP) begin
                        load_pc = 1'b1;
                    end else if (op_q == STO) begin
                        datactl_ena = 1'b1;
                        alu_ena     = 1'b1;
                    end
                end
                S5: begin
                    if (alu_op_c) begin
                        rd       = 1'b1;
                        load_acc = 1'b1;
                    end else if (op_q == SKZ) begin
                        inc_pc = zero;
                    end else if (op_q == JMP) begin
                        load_pc = 1'b1;
                        inc_pc  = 1'b1;
                    end else if (op_q == STO) begin
                        wr          = 1'b1;
                        datactl_ena = 1'b1;
                    end
                end
                S6: begin
                    if (alu_op_c) begin
                        rd = 1'b1;
                    end else if (op_q == STO) begin
                        datactl_ena = 1'b1;
                    end
                end
                S7: begin
                    inc_pc     = (op_q == SKZ) && zero;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;
    assign halt  = halted_q;

endmodule

// File: tb/tb_machine_ctrl.sv
// Directed bench for machine_ctrl: a reference model pushes expected output vectors
// to a scoreboard queue as stimulus is applied; they are popped and compared on the DUT outputs.
module tb_machine_ctrl;

    localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, ANDD = 3'b011;
    localparam logic [2:0] XORR = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] state;
    logic       inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, alu_ena, halt, instr_done;

    machine_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
        .state(state), .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
        .load_ir(load_ir), .rd(rd), .wr(wr), .datactl_ena(datactl_ena),
        .alu_ena(alu_ena), .halt(halt), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [2:0]  m_st;
    logic [2:0]  m_op;
    logic        m_h;
    logic [12:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Expected vector {state, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, alu_ena, halt, instr_done}
    function automatic logic [12:0] model_vec(input logic [2:0] st, input logic [2:0] op,
                                              input logic z, input logic e, input logic h);
        logic [7:0] s;   // inc, ldpc, ldacc, ldir, rd, wr, dctl, alu
        logic       done;
        logic       aluop;
        s     = 8'b0;
        done  = 1'b0;
        aluop = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
        if (e && !h) begin
            unique case (st)
                3'd0: s = 8'b0001_1000;
                3'd1: s = 8'b1001_1000;
                3'd2: s = 8'b0000_0000;
                3'd3: s = 8'b1000_0000;
                3'd4: s = aluop ? 8'b0000_1001 : (op == JMP) ? 8'b0100_0000 :
                          (op == STO) ? 8'b0000_0011 : 8'b0;
                3'd5: s = aluop ? 8'b0010_1000 : (op == JMP) ? 8'b1100_0000 :
                          (op == STO) ? 8'b0000_0110 : (op == SKZ && z) ? 8'b1000_0000 : 8'b0;
                3'd6: s = aluop ? 8'b0000_1000 : (op == STO) ? 8'b0000_0010 : 8'b0;
                3'd7: begin
                    s    = (op == SKZ && z) ? 8'b1000_0000 : 8'b0;
                    done = 1'b1;
                end
            endcase
        end
        return {st, s, h, done};
    endfunction

    task automatic check(input string tag);
        logic [12:0] obs, want;
        obs = {state, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, alu_ena, halt, instr_done};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: scoreboard empty, observed %013b", tag, obs);
        end else begin
            want = exp_q.pop_front();
            assert (obs === want) else begin
                n_err++;
                $error("FAIL %s: state=%0d observed %013b expected %013b", tag, m_st, obs, want);
            end
        end
    endtask

    // Drive inputs for the current state, push the model's expectation, then compare
    task automatic apply_check(input logic e, input logic [2:0] op, input logic z, input string tag);
        ena    = e;
        opcode = op;
        zero   = z;
        exp_q.push_back(model_vec(m_st, m_op, z, e, m_h));
        #2;
        check(tag);
    endtask

    // Advance one clock, stepping the model with the inputs that were held across the edge
    task automatic adv();
        logic [2:0] nst;
        logic [2:0] nop;
        logic       nh;
        nst = 3'd0;
        nop = m_op;
        nh  = m_h;
        if (ena && !m_h) begin
            if (m_st == 3'd2) nop = opcode;
            if (m_st == 3'd3 && m_op == HLT) begin
                nh = 1'b1;
            end else begin
                nst = 3'(m_st + 3'd1);
            end
        end
        @(posedge clk);
        #1;
        m_st = nst;
        m_op = nop;
        m_h  = nh;
    endtask

    task automatic run(input int n, input logic e, input logic [2:0] op, input logic z, input string tag);
        for (int i = 0; i < n; i++) begin
            apply_check(e, op, z, tag);
            adv();
        end
    endtask

    task automatic model_reset();
        m_st = 3'd0;
        m_op = HLT;
        m_h  = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        opcode = HLT;
        zero   = 1'b0;
        model_reset();
        #3;
        apply_check(1'b1, LDA, 1'b0, "reset");
        #7;
        rst_n = 1'b1;

        run(16, 1'b1, LDA, 1'b0, "lda");
        run(8, 1'b1, ADD, 1'b1, "add");
        run(8, 1'b1, STO, 1'b0, "sto");
        run(8, 1'b1, SKZ, 1'b1, "skz_z1");
        run(8, 1'b1, SKZ, 1'b0, "skz_z0");
        run(8, 1'b1, JMP, 1'b0, "jmp");

        // Abort STO by dropping ena in S5, then idle and re-run a clean instruction
        run(5, 1'b1, STO, 1'b0, "sto_pre");
        run(3, 1'b0, STO, 1'b0, "sto_abort");
        run(8, 1'b1, XORR, 1'b0, "xorr");

        // Async reset in the middle of the STO write cycle
        run(5, 1'b1, STO, 1'b0, "sto_pre2");
        apply_check(1'b1, STO, 1'b0, "sto_s5_wr");
        rst_n = 1'b0;
        #1;
        model_reset();
        apply_check(1'b1, STO, 1'b0, "async_rst");
        #1;
        rst_n = 1'b1;
        adv();
        run(15, 1'b1, ANDD, 1'b0, "andd");

        // HLT parks the sequencer regardless of ena until reset
        run(4, 1'b1, HLT, 1'b0, "hlt_run");
        for (int i = 0; i < 20; i++) begin
            apply_check(1'($urandom_range(0, 1)), LDA, 1'($urandom_range(0, 1)), "halted");
            adv();
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        apply_check(1'b1, LDA, 1'b0, "halt_clear");
        #1;
        rst_n = 1'b1;
        adv();
        run(9, 1'b1, LDA, 1'b0, "post_halt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
